myc64_prg_loader: RTL

//  Initiator for the myc64 external RAM write port (ext_we/ext_addr/ext_data/ext_ready).

---
 rtl/myc64_prg_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/myc64_prg_loader.sv
// Streams a .PRG image (little-endian load address, then payload) into C64 RAM through
// the myc64 external write port, optionally patching the BASIC end-of-program pointers.
module myc64_prg_loader #(
  parameter int          PATCH_BASIC_PTRS = 1,
  parameter logic [15:0] PTR_BASE         = 16'h002D,
  parameter int          PTR_COUNT        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_data,
  input  logic        i_ext_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_end_addr
);

  typedef enum logic [2:0] {
    S_ADDR_LO = 3'd0,
    S_ADDR_HI = 3'd1,
    S_DATA    = 3'd2,
    S_WRITE   = 3'd3,
    S_PTR     = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [7:0] PTR_LAST_IDX = 8'(2 * PTR_COUNT - 1);

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] addr_inc_d;
  logic        last_q;
  logic [7:0]  idx_q;
  logic        ext_we_q;
  logic [15:0] ext_addr_q;
  logic [7:0]  ext_data_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] end_addr_q;
  logic        xfer_s;

  assign o_ready    = (state_q == S_ADDR_LO) || (state_q == S_ADDR_HI) || (state_q == S_DATA);
  assign xfer_s     = i_valid & o_ready;
  assign addr_inc_d = addr_q + 16'd1;

  assign o_ext_we   = ext_we_q;
  assign o_ext_addr = ext_addr_q;
  assign o_ext_data = ext_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_end_addr = end_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ADDR_LO;
      addr_q     <= 16'h0000;
      last_q     <= 1'b0;
      idx_q      <= 8'h00;
      ext_we_q   <= 1'b0;
      ext_addr_q <= 16'h0000;
      ext_data_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      end_addr_q <= 16'h0000;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_ADDR_LO: begin
          if (xfer_s) begin
            addr_q[7:0] <= i_data;
            busy_q      <= 1'b1;
            state_q     <= i_last ? S_ERR : S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (xfer_s) begin
            addr_q[15:8] <= i_data;
            state_q      <= i_last ? S_ERR : S_DATA;
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            ext_addr_q <= addr_q;
            ext_data_q <= i_data;
            ext_we_q   <= 1'b1;
            last_q     <= i_last;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // address, data and strobe stay frozen until the RAM port acknowledges
          if (i_ext_ready) begin
            ext_we_q <= 1'b0;
            addr_q   <= addr_inc_d;
            if (last_q) begin
              end_addr_q <= addr_inc_d;
              idx_q      <= 8'h00;
              state_q    <= (PATCH_BASIC_PTRS != 0) ? S_PTR : S_DONE;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_PTR: begin
          // a write is raised only from the idle strobe, leaving a gap cycle between writes
          if (!ext_we_q) begin
            ext_we_q   <= 1'b1;
            ext_addr_q <= PTR_BASE + {8'h00, idx_q};
            ext_data_q <= idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
          end else if (i_ext_ready) begin
            ext_we_q <= 1'b0;
            idx_q    <= idx_q + 8'd1;
            if (idx_q == PTR_LAST_IDX) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_ADDR_LO;
        end
        S_ERR: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_ADDR_LO;
        end
        default: begin
          ext_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_ADDR_LO;
        end
      endcase
    end
  end

endmodule
